// File: rtl/b_to_grey_pkg.sv
// Shared constants and mode encoding for the b_to_grey converter.
// Optional feature macro used by the slice: B_TO_GREY_STEP_CHECK_EN.
package b_to_grey_pkg;

  localparam int GREY_WIDTH_DEF = 4;
  // Popcount result width; 6 bits covers the widest legal word (32).
  localparam int STEP_CNT_W     = 6;

  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } grey_mode_e;

endpackage

// File: rtl/grey_xor_core.sv
// Combinational binary<->Gray conversion, plus a changed-bit count when
// B_TO_GREY_STEP_CHECK_EN is defined.
module grey_xor_core
  import b_to_grey_pkg::*;
#(
  parameter int WIDTH = GREY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0]      i_code,
  input  logic                  i_mode,
  output logic [WIDTH-1:0]      o_conv
`ifdef B_TO_GREY_STEP_CHECK_EN
  ,
  input  logic [WIDTH-1:0]      i_prev,
  output logic [STEP_CNT_W-1:0] o_diff_cnt
`endif
);

  function automatic logic [WIDTH-1:0] bin2grey(input logic [WIDTH-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] grey2bin(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = x[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ x[i];
    end
    return r;
  endfunction

  function automatic logic [STEP_CNT_W-1:0] popcount(input logic [WIDTH-1:0] x);
    logic [STEP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + STEP_CNT_W'(x[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;

  always_comb begin
    w_b2g  = bin2grey(i_code);
    w_g2b  = grey2bin(i_code);
    o_conv = (grey_mode_e'(i_mode) == MODE_G2B) ? w_g2b : w_b2g;
  end

`ifdef B_TO_GREY_STEP_CHECK_EN
  always_comb begin
    o_diff_cnt = popcount(w_b2g ^ i_prev);
  end
`endif

endmodule

// File: rtl/b_to_grey.sv
// Registered binary-to-Gray / Gray-to-binary converter, one-cycle latency.
// Optional Gray step checker (step_err output) under B_TO_GREY_STEP_CHECK_EN.
module b_to_grey
  import b_to_grey_pkg::*;
#(
  parameter int WIDTH = GREY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             out_valid
`ifdef B_TO_GREY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  logic [WIDTH-1:0] w_conv;
  logic [WIDTH-1:0] r_g;
  logic             r_out_valid;

`ifdef B_TO_GREY_STEP_CHECK_EN
  logic [STEP_CNT_W-1:0] w_diff_cnt;
  logic [WIDTH-1:0]      r_hist;
  logic                  r_hist_vld;
  logic                  r_step_err;
`endif

  grey_xor_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_code     (b),
    .i_mode     (mode),
    .o_conv     (w_conv)
`ifdef B_TO_GREY_STEP_CHECK_EN
    ,
    .i_prev     (r_hist),
    .o_diff_cnt (w_diff_cnt)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_g <= w_conv;
      end
    end
  end

`ifdef B_TO_GREY_STEP_CHECK_EN
  // History tracks only binary-to-Gray results; the first one after reset never flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist     <= '0;
      r_hist_vld <= 1'b0;
      r_step_err <= 1'b0;
    end else if (in_valid) begin
      if (grey_mode_e'(mode) == MODE_B2G) begin
        r_step_err <= r_hist_vld && (w_diff_cnt > STEP_CNT_W'(1));
        r_hist     <= w_conv;
        r_hist_vld <= 1'b1;
      end else begin
        r_step_err <= 1'b0;
      end
    end
  end

  assign step_err = r_step_err;
`endif

  assign g         = r_g;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_b_to_grey.sv
// Directed self-checking bench for b_to_grey (WIDTH=4), step checker covered
// when B_TO_GREY_STEP_CHECK_EN is defined.
module tb_b_to_grey;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       mode;
  logic [3:0] b;
  logic [3:0] g;
  logic       out_valid;
`ifdef B_TO_GREY_STEP_CHECK_EN
  logic       step_err;
`endif

  int total = 0;
  int bad   = 0;

  b_to_grey #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .b         (b),
    .g         (g),
    .out_valid (out_valid)
`ifdef B_TO_GREY_STEP_CHECK_EN
    ,
    .step_err  (step_err)
`endif
  );

  always #5 clk = ~clk;

  // Hand-computed Gray codes for binary 0..15.
  logic [3:0] gray_tab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic m, input logic [3:0] val);
    @(negedge clk);
    in_valid = v;
    mode     = m;
    b        = val;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input string tag, input logic exp);
`ifdef B_TO_GREY_STEP_CHECK_EN
    chk(tag, {31'b0, step_err}, {31'b0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    logic [3:0] captured;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    b        = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_g", {28'b0, g}, 32'h0);
    chk("reset_vld", {31'b0, out_valid}, 32'h0);
    chk_step("reset_step", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Binary-to-Gray sweep, ending with the 15 -> 0 wrap.
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'b0, 4'(i));
      chk($sformatf("sweep_g_%0d", i), {28'b0, g}, {28'b0, gray_tab[i]});
      chk($sformatf("sweep_vld_%0d", i), {31'b0, out_valid}, 32'h1);
      chk_step($sformatf("sweep_step_%0d", i), 1'b0);
    end
    beat(1'b1, 1'b0, 4'd0);
    chk("wrap_g", {28'b0, g}, 32'h0);
    chk_step("wrap_step", 1'b0);

    // Two-bit jump 0000 -> 0011 flags, then a legal one-bit step clears it.
    beat(1'b1, 1'b0, 4'd2);
    chk("jump_g", {28'b0, g}, 32'h3);
    chk_step("jump_step", 1'b1);
    beat(1'b1, 1'b0, 4'd3);
    chk("step_ok_g", {28'b0, g}, 32'h2);
    chk_step("step_ok_step", 1'b0);

    // Gray-to-binary directed vectors.
    beat(1'b1, 1'b0, 4'd0);
    beat(1'b1, 1'b0, 4'd2);
    chk_step("pre_g2b_step", 1'b1);
    beat(1'b1, 1'b1, 4'b1000);
    chk("g2b_1000", {28'b0, g}, 32'hF);
    chk_step("g2b_clear_step", 1'b0);
    beat(1'b1, 1'b1, 4'b0110);
    chk("g2b_0110", {28'b0, g}, 32'h4);
    beat(1'b1, 1'b1, 4'b1101);
    chk("g2b_1101", {28'b0, g}, 32'h9);
    chk("g2b_vld", {31'b0, out_valid}, 32'h1);

    // Round trip over all codes.
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'b0, 4'(i));
      captured = g;
      beat(1'b1, 1'b1, captured);
      chk($sformatf("round_trip_%0d", i), {28'b0, g}, i);
    end

    // Hold: idle cycles with changing b/mode leave g alone.
    beat(1'b1, 1'b0, 4'd5);
    chk("hold_pre_g", {28'b0, g}, 32'h7);
    beat(1'b0, 1'b1, 4'd9);
    chk("hold0_g", {28'b0, g}, 32'h7);
    chk("hold0_vld", {31'b0, out_valid}, 32'h0);
    beat(1'b0, 1'b0, 4'd14);
    chk("hold1_g", {28'b0, g}, 32'h7);
    chk("hold1_vld", {31'b0, out_valid}, 32'h0);
    beat(1'b0, 1'b1, 4'd3);
    chk("hold2_g", {28'b0, g}, 32'h7);
    chk("hold2_vld", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset between clock edges.
    beat(1'b1, 1'b0, 4'd12);
    chk("pre_rst_g", {28'b0, g}, 32'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_g", {28'b0, g}, 32'h0);
    chk("async_rst_vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 1'b0, 4'd3);
    chk("post_rst_g", {28'b0, g}, 32'h2);
    chk("post_rst_vld", {31'b0, out_valid}, 32'h1);
    chk_step("post_rst_step", 1'b0);
    beat(1'b0, 1'b0, 4'd0);
    chk("single_vld", {31'b0, out_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
